decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, width of in_pc and out_pc.
REQ-002 Parameter EN_M, default 0, 1 = decode RV32M mul/div, 0 = treat them as illegal.
REQ-003 Parameter LOAD_BUBBLES, default 1, legal range 1..3, bubbles inserted between a load and a dependent instruction.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  stage accepts the input this cycle.
REQ-008 in_instr  in  32  instruction word.
REQ-009 in_pc  in  XLEN  instruction PC.
REQ-010 flush  in  1  kill the held instruction and block input.
REQ-011 out_valid  out  1  decoded instruction valid.
REQ-012 out_ready  in  1  downstream accepts the output.
REQ-013 out_instr / out_pc  out  32 / XLEN  registered copies of the accepted inputs.
REQ-014 out_ctrl  out  17  packed MSB to LSB: {jump, branch, store, regWrite, memWE2, memRDEN2, alu_fun[3:0], alu_srca[1:0], alu_srcb[2:0], rf_wr_sel[1:0]}.
REQ-015 out_muldiv  out  1  M-extension op; out_illegal  out  1  undecodable instruction.

Function
REQ-016 Decode table by opcode; every unlisted field is 0:
- 0110011 (funct7 0000000 or 0100000): alu_fun={i[30],f3}, rf_wr_sel=11, regWrite.
- 0010011: alu_fun={(f3==101)?i[30]:0, f3}, srcb=001, rf_wr_sel=11, regWrite.
- 0000011: srcb=001, rf_wr_sel=10, regWrite, memRDEN2.
- 0100011: srcb=010, memWE2, store.
- 1100011: branch.
- 1101111 and 1100111: rf_wr_sel=00, regWrite, jump.
- 0110111: alu_fun=1001, srca=01, rf_wr_sel=11, regWrite.
- 0010111: srca=01, srcb=011, rf_wr_sel=11, regWrite.
REQ-017 Mul/div encoding (opcode 0110011, funct7 0000001):
- EN_M=1: out_muldiv=1, alu_fun={0,f3}, rf_wr_sel=11, regWrite.
- EN_M=0: illegal.
REQ-018 Illegal handling:
- Triggers: any other opcode, or an R-type funct7 not covered by REQ-016/017.
- Output: out_illegal=1, out_ctrl=0.
- An illegal instruction still passes the handshake normally.
REQ-019 Register usage:
- rs1 (i[19:15]) is used by R, I-ALU, load, store, branch and jalr.
- rs2 (i[24:20]) is used by R, store and branch.
REQ-020 hazard=1 when the input uses rs1 or rs2 equal to a nonzero load rd from either source:
- (a) the held output: out_valid=1 with memRDEN2=1.
- (b) haz_rd while haz_cnt>0.
REQ-021 in_ready = !flush && !hazard && (!out_valid || out_ready), evaluated combinationally.
REQ-022 Input accept (in_valid && in_ready): decode and all out_* registers load on the same edge, giving 1-cycle latency; out_valid=1 next cycle.
REQ-023 Output drain: out_valid && out_ready with no accept sets out_valid=0 next cycle. A full register with out_ready=0 holds every out_* stable.
REQ-024 Load leaves the stage (transfer with memRDEN2=1, rd!=0): haz_rd<=rd and haz_cnt<=LOAD_BUBBLES-1 on the same edge.
REQ-025 haz_cnt decrements by 1 each cycle it is >0 and the output is not stalled (out_valid && !out_ready); it saturates at 0.
REQ-026 Flush:
- out_valid<=0 on the next edge.
- Same cycle: in_ready=0 and no accept.
- haz_cnt and haz_rd are unaffected.
REQ-027 Flush has priority over accept and drain when they occur in the same cycle.
REQ-028 rd=x0 loads never create a hazard.
REQ-029 Back-to-back independent instructions sustain 1 instruction/cycle.

Reset
REQ-030 RST_N=0 asynchronously clears: out_valid, out_instr, out_pc, out_ctrl, out_muldiv, out_illegal, haz_cnt, haz_rd.
REQ-031 While RST_N=0, in_ready=0. In-flight instructions are discarded. Operation resumes on the first edge after release.

Verification
REQ-032 add x3,x1,x2 (0x002081B3), out_ready=1: out_valid after 1 cycle, out_ctrl = regWrite, alu_fun=0000, rf_wr_sel=11.
REQ-033 lw x5,0(x1) then add x6,x5,x0, out_ready=1, LOAD_BUBBLES=1: exactly one out_valid=0 cycle between them. With LOAD_BUBBLES=3: three such cycles.
REQ-034 Valid output with out_ready=0 for 4 cycles: out_* stable, in_ready=0. Release: the next instruction appears the following cycle.
REQ-035 flush while holding a valid sub (funct7 0100000): out_valid=0 next cycle, the concurrent input is not accepted, and a pending haz_cnt still blocks a dependent instruction.
REQ-036 Opcode 0x7F, or mul with EN_M=0: out_illegal=1, out_ctrl=0. The same mul with EN_M=1: out_muldiv=1, regWrite=1.
REQ-037 RST_N low mid-stall with haz_cnt=2: all outputs 0 immediately. After release, the dependent instruction is accepted without a bubble.

Source files
------------

// File: rtl/decode_stage.sv
// RV32 decode stage: one-entry output register with load-use interlock.
// Latency: 1 cycle from input accept to out_valid; sustains 1 instr/cycle.
// Backpressure: in_ready drops on flush, load-use hazard or a full, stalled output.
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int EN_M         = 0,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [16:0]     out_ctrl,
    output logic            out_muldiv,
    output logic            out_illegal
);

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       store;
        logic       reg_write;
        logic       mem_we2;
        logic       mem_rden2;
        logic [3:0] alu_fun;
        logic [1:0] alu_srca;
        logic [2:0] alu_srcb;
        logic [1:0] rf_wr_sel;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] HAZ_INIT = 2'(LOAD_BUBBLES - 1);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] held_rd;

    ctrl_t dec_ctrl;
    ctrl_t ctrl_q;
    logic  dec_muldiv;
    logic  dec_illegal;
    logic  use_rs1;
    logic  use_rs2;

    logic [1:0] haz_cnt;
    logic [4:0] haz_rd;
    logic       held_ld_vld;
    logic       cnt_ld_vld;
    logic       hazard;
    logic       accept;
    logic       xfer;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign rs1     = in_instr[19:15];
    assign rs2     = in_instr[24:20];
    assign held_rd = out_instr[11:7];

    always_comb begin
        dec_ctrl    = '0;
        dec_muldiv  = 1'b0;
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    dec_ctrl.alu_fun   = {in_instr[30], funct3};
                    dec_ctrl.rf_wr_sel = 2'b11;
                    dec_ctrl.reg_write = 1'b1;
                end else if (funct7 == 7'b0000001 && EN_M != 0) begin
                    dec_muldiv         = 1'b1;
                    dec_ctrl.alu_fun   = {1'b0, funct3};
                    dec_ctrl.rf_wr_sel = 2'b11;
                    dec_ctrl.reg_write = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                use_rs1            = 1'b1;
                dec_ctrl.alu_fun   = {(funct3 == 3'b101) ? in_instr[30] : 1'b0, funct3};
                dec_ctrl.alu_srcb  = 3'b001;
                dec_ctrl.rf_wr_sel = 2'b11;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_LOAD: begin
                use_rs1            = 1'b1;
                dec_ctrl.alu_srcb  = 3'b001;
                dec_ctrl.rf_wr_sel = 2'b10;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_rden2 = 1'b1;
            end
            OP_STORE: begin
                use_rs1           = 1'b1;
                use_rs2           = 1'b1;
                dec_ctrl.alu_srcb = 3'b010;
                dec_ctrl.mem_we2  = 1'b1;
                dec_ctrl.store    = 1'b1;
            end
            OP_BRANCH: begin
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                dec_ctrl.branch = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                use_rs1            = (opcode == OP_JALR);
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
            end
            OP_LUI: begin
                dec_ctrl.alu_fun   = 4'b1001;
                dec_ctrl.alu_srca  = 2'b01;
                dec_ctrl.rf_wr_sel = 2'b11;
                dec_ctrl.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec_ctrl.alu_srca  = 2'b01;
                dec_ctrl.alu_srcb  = 3'b011;
                dec_ctrl.rf_wr_sel = 2'b11;
                dec_ctrl.reg_write = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // A load is a hazard source both while still held here and for the bubble window after it leaves.
    assign held_ld_vld = out_valid && ctrl_q.mem_rden2 && (held_rd != 5'd0);
    assign cnt_ld_vld  = (haz_cnt != 2'd0) && (haz_rd != 5'd0);

    assign hazard = (use_rs1 && ((held_ld_vld && rs1 == held_rd) || (cnt_ld_vld && rs1 == haz_rd)))
                 || (use_rs2 && ((held_ld_vld && rs2 == held_rd) || (cnt_ld_vld && rs2 == haz_rd)));

    assign in_ready = RST_N && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready && !flush;
    assign out_ctrl = ctrl_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            ctrl_q      <= '0;
            out_muldiv  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            ctrl_q      <= dec_ctrl;
            out_muldiv  <= dec_muldiv;
            out_illegal <= dec_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            haz_cnt <= 2'd0;
            haz_rd  <= 5'd0;
        end else if (xfer && ctrl_q.mem_rden2 && held_rd != 5'd0) begin
            haz_rd  <= held_rd;
            haz_cnt <= HAZ_INIT;
        end else if (haz_cnt != 2'd0 && !(out_valid && !out_ready)) begin
            haz_cnt <= haz_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: instance a (EN_M=0, LOAD_BUBBLES=1) and instance b (EN_M=1, LOAD_BUBBLES=3)
// share one stimulus stream; each phase checks the instance it targets.
module tb_decode_stage;

    logic        CLK;
    logic        RST_N;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_muldiv, a_out_illegal;
    logic [31:0] a_out_instr, a_out_pc;
    logic [16:0] a_out_ctrl;
    logic        b_in_ready, b_out_valid, b_out_muldiv, b_out_illegal;
    logic [31:0] b_out_instr, b_out_pc;
    logic [16:0] b_out_ctrl;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4030D213;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_LUI  = 32'h123453B7;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_ILL  = 32'h0000007F;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_ADD6 = 32'h00028333;
    localparam logic [31:0] I_SUB8 = 32'h40208433;

    localparam logic [31:0] C_ADD  = 32'h0000_2003;
    localparam logic [31:0] C_SUB  = 32'h0000_2403;
    localparam logic [31:0] C_SRAI = 32'h0000_2687;
    localparam logic [31:0] C_SW   = 32'h0000_5008;
    localparam logic [31:0] C_LUI  = 32'h0000_24A3;
    localparam logic [31:0] C_JAL  = 32'h0001_2000;
    localparam logic [31:0] C_LW   = 32'h0000_2806;

    decode_stage #(.XLEN(32), .EN_M(0), .LOAD_BUBBLES(1)) dut_a (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_out_instr), .out_pc(a_out_pc), .out_ctrl(a_out_ctrl),
        .out_muldiv(a_out_muldiv), .out_illegal(a_out_illegal)
    );

    decode_stage #(.XLEN(32), .EN_M(1), .LOAD_BUBBLES(3)) dut_b (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr(b_out_instr), .out_pc(b_out_pc), .out_ctrl(b_out_ctrl),
        .out_muldiv(b_out_muldiv), .out_illegal(b_out_illegal)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] vec_instr [7];
    logic [31:0] vec_ctrl  [7];
    logic        vec_ill   [7];
    int          bub;

    initial begin
        vec_instr = '{I_SUB, I_SRAI, I_SW, I_LUI, I_JAL, I_ILL, I_MUL};
        vec_ctrl  = '{C_SUB, C_SRAI, C_SW, C_LUI, C_JAL, 32'h0, 32'h0};
        vec_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        RST_N     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADD;
        in_pc     = 32'h100;
        flush     = 1'b0;
        out_ready = 1'b1;

        // reset state, with a valid input already presented
        #12;
        check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_a_in_ready", {31'd0, a_in_ready}, 32'd0);
        check("rst_b_in_ready", {31'd0, b_in_ready}, 32'd0);
        check("rst_a_out_ctrl", {15'd0, a_out_ctrl}, 32'd0);
        check("rst_a_out_instr", a_out_instr, 32'd0);
        check("rst_a_out_pc", a_out_pc, 32'd0);
        RST_N = 1'b1;
        #1;
        check("rel_a_in_ready", {31'd0, a_in_ready}, 32'd1);

        // add x3,x1,x2: one-cycle latency
        tick();
        check("add_out_valid", {31'd0, a_out_valid}, 32'd1);
        check("add_out_instr", a_out_instr, I_ADD);
        check("add_out_pc", a_out_pc, 32'h100);
        check("add_out_ctrl", {15'd0, a_out_ctrl}, C_ADD);
        check("add_out_illegal", {31'd0, a_out_illegal}, 32'd0);

        // back-to-back decode table, one instruction per cycle
        for (int i = 0; i < 7; i++) begin
            in_instr = vec_instr[i];
            in_pc    = 32'h104 + 32'(4 * i);
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, a_out_valid}, 32'd1);
            check($sformatf("vec%0d_ctrl", i), {15'd0, a_out_ctrl}, vec_ctrl[i]);
            check($sformatf("vec%0d_illegal", i), {31'd0, a_out_illegal}, {31'd0, vec_ill[i]});
            check($sformatf("vec%0d_pc", i), a_out_pc, 32'h104 + 32'(4 * i));
        end
        check("mul_a_muldiv", {31'd0, a_out_muldiv}, 32'd0);
        check("mul_b_muldiv", {31'd0, b_out_muldiv}, 32'd1);
        check("mul_b_ctrl", {15'd0, b_out_ctrl}, C_ADD);
        check("mul_b_illegal", {31'd0, b_out_illegal}, 32'd0);

        // load-use with one bubble
        in_instr = I_LW;
        in_pc    = 32'h200;
        tick();
        check("lw_a_ctrl", {15'd0, a_out_ctrl}, C_LW);
        in_instr = I_ADD6;
        in_pc    = 32'h204;
        #1;
        check("lw_a_dep_blocked", {31'd0, a_in_ready}, 32'd0);
        tick();
        check("lw_a_bubble", {31'd0, a_out_valid}, 32'd0);
        check("lw_a_dep_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        check("lw_a_dep_valid", {31'd0, a_out_valid}, 32'd1);
        check("lw_a_dep_instr", a_out_instr, I_ADD6);

        // output stall for four cycles
        out_ready = 1'b0;
        in_instr  = I_LUI;
        in_pc     = 32'h208;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("stall%0d_in_ready", i), {31'd0, a_in_ready}, 32'd0);
            tick();
            check($sformatf("stall%0d_valid", i), {31'd0, a_out_valid}, 32'd1);
            check($sformatf("stall%0d_instr", i), a_out_instr, I_ADD6);
            check($sformatf("stall%0d_pc", i), a_out_pc, 32'h204);
            check($sformatf("stall%0d_ctrl", i), {15'd0, a_out_ctrl}, C_ADD);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        check("unstall_instr", a_out_instr, I_LUI);
        check("unstall_pc", a_out_pc, 32'h208);
        in_valid = 1'b0;
        tick();
        check("drain_valid", {31'd0, a_out_valid}, 32'd0);

        // instance b: three bubbles after a load
        RST_N = 1'b0;
        #1;
        check("b_rst_valid", {31'd0, b_out_valid}, 32'd0);
        RST_N    = 1'b1;
        in_valid = 1'b1;
        in_instr = I_LW;
        in_pc    = 32'h300;
        tick();
        check("b_lw_ctrl", {15'd0, b_out_ctrl}, C_LW);
        in_instr = I_ADD6;
        in_pc    = 32'h304;
        bub = 0;
        while (bub < 10) begin
            tick();
            if (b_out_valid) break;
            bub++;
        end
        check("b_bubbles", 32'(bub), 32'd3);
        check("b_dep_instr", b_out_instr, I_ADD6);

        // flush of a held sub while a load bubble window is still pending
        in_instr = I_LW;
        in_pc    = 32'h310;
        tick();
        check("fl_lw_instr", b_out_instr, I_LW);
        in_instr = I_SUB8;
        in_pc    = 32'h314;
        #1;
        check("fl_sub_ready", {31'd0, b_in_ready}, 32'd1);
        tick();
        check("fl_sub_ctrl", {15'd0, b_out_ctrl}, C_SUB);
        flush     = 1'b1;
        out_ready = 1'b0;
        in_instr  = I_ADD6;
        in_pc     = 32'h318;
        #1;
        check("fl_in_ready", {31'd0, b_in_ready}, 32'd0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        check("fl_out_valid", {31'd0, b_out_valid}, 32'd0);
        check("fl_not_accepted", b_out_instr, I_SUB8);
        #1;
        check("fl_haz_block0", {31'd0, b_in_ready}, 32'd0);
        tick();
        check("fl_haz_block1", {31'd0, b_in_ready}, 32'd0);
        tick();
        check("fl_haz_release", {31'd0, b_in_ready}, 32'd1);
        tick();
        check("fl_dep_valid", {31'd0, b_out_valid}, 32'd1);
        check("fl_dep_instr", b_out_instr, I_ADD6);

        // reset in the middle of a stall with a pending bubble window
        in_instr = I_LW;
        in_pc    = 32'h320;
        tick();
        in_instr = I_SUB8;
        in_pc    = 32'h324;
        tick();
        check("mr_sub_instr", b_out_instr, I_SUB8);
        out_ready = 1'b0;
        in_instr  = I_ADD6;
        in_pc     = 32'h328;
        #1;
        check("mr_stall_ready", {31'd0, b_in_ready}, 32'd0);
        tick();
        RST_N = 1'b0;
        #1;
        check("mr_out_valid", {31'd0, b_out_valid}, 32'd0);
        check("mr_out_instr", b_out_instr, 32'd0);
        check("mr_out_pc", b_out_pc, 32'd0);
        check("mr_out_ctrl", {15'd0, b_out_ctrl}, 32'd0);
        check("mr_in_ready", {31'd0, b_in_ready}, 32'd0);
        RST_N     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mr_rel_ready", {31'd0, b_in_ready}, 32'd1);
        tick();
        check("mr_dep_valid", {31'd0, b_out_valid}, 32'd1);
        check("mr_dep_instr", b_out_instr, I_ADD6);
        check("mr_dep_pc", b_out_pc, 32'h328);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
